pe_driver: RTL

Feeder and collector for one processing element. Accepts a dot-product job (one A row, one B column) over a valid/ready handshake. Drives the PE's `load_row`/`start`/`row`/`col_entry` protocol with correct beat alignment, then captures the PE's `total`/`err` on its `done` pulse. Returns the captured result over a second valid/ready handshake. Sits between the tile scheduler and each PE instance in the multiplier array.

---
 rtl/pe_driver.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pe_driver.sv
// Feeds one dot-product job to a PE, streams column beats, and returns the captured result.
// Optional watchdog abort in WAIT is enabled by defining PE_DRIVER_TIMEOUT_EN.
module pe_driver #(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
    parameter int TIMEOUT     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               job_valid,
    output logic                               job_ready,
    input  logic signed [N*DATA_WIDTH-1:0]     job_row,
    input  logic signed [N*DATA_WIDTH-1:0]     job_col,
    output logic                               pe_load_row,
    output logic                               pe_start,
    output logic signed [N*DATA_WIDTH-1:0]     pe_row,
    output logic signed [DATA_WIDTH-1:0]       pe_col_entry,
    input  logic                               pe_done,
    input  logic                               pe_err,
    input  logic signed [ACCUM_WIDTH-1:0]      pe_total,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic signed [ACCUM_WIDTH-1:0]      res_total,
    output logic                               res_err,
    output logic                               res_timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_STREAM, S_WAIT, S_RESULT} state_t;

    state_t                         state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]   row_buf_q [N];
    logic signed [DATA_WIDTH-1:0]   col_buf_q [N];
    logic signed [ACCUM_WIDTH-1:0]  total_q, total_d;
    logic                           err_q, err_d;
    logic                           accept;

    assign accept = job_valid & job_ready;

`ifdef PE_DRIVER_TIMEOUT_EN
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          tmo_q, tmo_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < N; k++) begin
                row_buf_q[k] <= '0;
                col_buf_q[k] <= '0;
            end
        end else if (accept) begin
            for (int unsigned k = 0; k < N; k++) begin
                row_buf_q[k] <= job_row[k*DATA_WIDTH +: DATA_WIDTH];
                col_buf_q[k] <= job_col[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef PE_DRIVER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign res_timeout = tmo_q;
`else
    assign res_timeout = 1'b0;
`endif

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            pe_row[k*DATA_WIDTH +: DATA_WIDTH] = row_buf_q[k];
        end
    end

    assign res_total = total_q;
    assign res_err   = err_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        total_d      = total_q;
        err_d        = err_q;
        job_ready    = 1'b0;
        pe_load_row  = 1'b0;
        pe_start     = 1'b0;
        pe_col_entry = '0;
        res_valid    = 1'b0;
`ifdef PE_DRIVER_TIMEOUT_EN
        wcnt_d       = wcnt_q;
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pe_load_row  = 1'b1;
                pe_start     = 1'b1;
                pe_col_entry = col_buf_q[0];
                idx_d        = '0;
                state_d      = S_STREAM;
            end
            S_STREAM: begin
                pe_col_entry = col_buf_q[idx_q];
                if (idx_q == IW'(N-1)) begin
                    state_d = S_WAIT;
`ifdef PE_DRIVER_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Last beat stays on the bus for the PE's registered final add.
                pe_col_entry = col_buf_q[N-1];
                if (pe_done) begin
                    total_d = pe_total;
                    err_d   = pe_err;
`ifdef PE_DRIVER_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                    state_d = S_RESULT;
                end
`ifdef PE_DRIVER_TIMEOUT_EN
                else if (wcnt_q == WW'(TIMEOUT-1)) begin
                    total_d = '0;
                    err_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
